axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter RAM_AW, default 16, meaning SRAM word-address width (2^RAM_AW 32-bit words).
REQ-002 SHALL have clk  in  1  clock; all logic on the rising edge.
REQ-003 SHALL have resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have AR channel: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 SHALL have R channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have AW channel: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 SHALL have W channel: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1; B channel: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have SRAM port: ram_en out 1, ram_we out 4 (byte write enables), ram_addr out RAM_AW, ram_wdata out 32, ram_rdata in 32.
REQ-009 arlock/arcache/arprot/awlock/awcache/awprot/wid SHALL be accepted and ignored.

Function
REQ-010 SHALL be a single-outstanding slave, FSM states IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.
REQ-011 IDLE: arready/awready combinational, high only in IDLE; AR and AW never both accepted in one cycle.
REQ-012 Arbitration: only arvalid -> accept AR; only awvalid -> accept AW; both -> side selected by prio bit (0 = read); prio toggles on every completed transaction (R with rlast, or B handshake).
REQ-013 AR handshake -> latch rid<=arid, addr<=araddr, len<=arlen, size, burst; beat counter <=0; go RD_REQ.
REQ-014 RD_REQ (one cycle): ram_en=1, ram_we=0, ram_addr=addr[RAM_AW+1:2]; go RD_RESP, rvalid<=1.
REQ-015 SRAM SHALL return data one cycle after ram_en and hold ram_rdata while ram_en low; rdata SHALL equal ram_rdata in RD_RESP (0 on error beats and when rvalid low).
REQ-016 RD_RESP: rvalid, rdata, rresp stable until rready; rlast=1 when counter==len; on handshake: last -> IDLE, else counter+1, addr advanced, -> RD_REQ.
REQ-017 Read latency: AR handshake in cycle T -> rvalid in T+2; one beat per 2 cycles minimum.
REQ-018 AW handshake -> latch bid, addr, len, size, burst; counter<=0; bresp_acc<=OKAY; go WR_DATA.
REQ-019 WR_DATA: wready=1; on W handshake ram_en=1, ram_we=wstrb (0 if beat in error), ram_addr from addr, ram_wdata=wdata, same cycle.
REQ-020 Write terminates on beat counter==len regardless of wlast; wlast != (counter==len) on any beat sets bresp_acc=SLVERR (2'b10).
REQ-021 After last W beat -> WR_RESP, bvalid<=1, bresp=bresp_acc; hold until bready; then IDLE.
REQ-022 Address advance: burst 00 FIXED holds addr; 01 INCR and 10 WRAP add (1<<size); ram_addr wraps modulo 2^RAM_AW.
REQ-023 Error: size>2 or burst==11 -> every beat of that burst SLVERR, no SRAM write, read data 0; beat count still honoured.
REQ-024 Otherwise rresp/bresp SHALL be OKAY (00); EXOKAY never returned.
REQ-025 ram_en SHALL be 0 in IDLE, RD_RESP, WR_RESP and in WR_DATA without a W handshake.

Reset
REQ-026 resetn low at a clock edge -> state IDLE, prio=0, counter=0, rvalid=0, bvalid=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0.
REQ-027 While resetn low: arready=awready=wready=0, ram_en=0, ram_we=0; reset mid-burst abandons the burst, no further SRAM write.

Verification
REQ-028 Single read: preload word 0x10 = 0xDEADBEEF; AR araddr=0x40, arlen=0, arsize=2, arid=3, rready=1 -> rvalid at T+2, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00.
REQ-029 INCR write burst: awaddr=0x100, awlen=3, awsize=2, wstrb=0xF, data 1..4, wlast on beat 4 -> SRAM words 0x40..0x43 = 1..4, one B with bresp=00, bid echoed.
REQ-030 Byte strobe + FIXED: awburst=00, awlen=1, wstrb 0x1 then 0x8 at 0x200 -> only bytes 0 and 3 of word 0x80 changed.
REQ-031 Simultaneous arvalid+awvalid after reset -> read accepted first, write accepted after rlast; next simultaneous pair -> write first.
REQ-032 Errors: arsize=3, arlen=1 -> two beats rresp=10, rdata=0; write awlen=1 with wlast on beat 1 -> 2 beats written, bresp=10; rready held low 5 cycles -> rdata/rvalid stable.
REQ-033 Reset asserted during beat 2 of 4-beat write -> outputs at reset values next cycle, ram_en=0, remaining beats not written.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one outstanding read or write burst onto a single-port synchronous SRAM.
// Reads take two cycles per beat (address, then data); writes go straight to the SRAM on each W handshake.
module axi_sram_slave #(
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,

    output logic [2:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid-side payloads are held by the master until then, and R/B payloads here are held likewise.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    state_t      state;
    logic        prio;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  cnt;
    logic        err;
    logic [1:0]  bresp_acc;

    logic        idle;
    logic        sel_rd;
    logic        sel_wr;
    logic        w_hs;
    logic        is_last;
    logic        ar_err;
    logic        aw_err;
    logic [31:0] next_addr;
    logic [1:0]  wr_resp_next;

    // Attribute inputs carry no meaning for a plain SRAM.
    logic unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, addr};

    always_comb begin
        idle         = resetn && (state == IDLE);
        // prio picks the winner only when both address channels are valid together
        sel_rd       = arvalid && (!awvalid || !prio);
        sel_wr       = awvalid && (!arvalid || prio);
        arready      = idle && !sel_wr;
        awready      = idle && !sel_rd;
        wready       = resetn && (state == WR_DATA);
        w_hs         = wready && wvalid;
        is_last      = (cnt == len);
        ar_err       = (arsize > 3'd2) || (arburst == BURST_RSVD);
        aw_err       = (awsize > 3'd2) || (awburst == BURST_RSVD);
        next_addr    = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
        wr_resp_next = (err || (wlast != is_last)) ? RESP_SLVERR : bresp_acc;

        ram_en       = resetn && ((state == RD_REQ) || w_hs);
        ram_we       = (w_hs && !err) ? wstrb : 4'b0000;
        ram_addr     = addr[RAM_AW+1:2];
        ram_wdata    = wdata;
        rdata        = ((state == RD_RESP) && rvalid && !err) ? ram_rdata : 32'd0;
        dbg_state    = state;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            prio      <= 1'b0;
            addr      <= 32'd0;
            len       <= 8'd0;
            size      <= 3'd0;
            burst     <= 2'b00;
            cnt       <= 8'd0;
            err       <= 1'b0;
            bresp_acc <= RESP_OKAY;
            rid       <= 4'd0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= RESP_OKAY;
            bid       <= 4'd0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid && arready) begin
                        rid   <= arid;
                        addr  <= araddr;
                        len   <= arlen;
                        size  <= arsize;
                        burst <= arburst;
                        err   <= ar_err;
                        cnt   <= 8'd0;
                        state <= RD_REQ;
                    end else if (awvalid && awready) begin
                        bid       <= awid;
                        addr      <= awaddr;
                        len       <= awlen;
                        size      <= awsize;
                        burst     <= awburst;
                        err       <= aw_err;
                        cnt       <= 8'd0;
                        bresp_acc <= aw_err ? RESP_SLVERR : RESP_OKAY;
                        state     <= WR_DATA;
                    end
                end

                RD_REQ: begin
                    rvalid <= 1'b1;
                    rlast  <= is_last;
                    rresp  <= err ? RESP_SLVERR : RESP_OKAY;
                    state  <= RD_RESP;
                end

                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        rresp  <= RESP_OKAY;
                        if (rlast) begin
                            prio  <= ~prio;
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + 8'd1;
                            addr  <= next_addr;
                            state <= RD_REQ;
                        end
                    end
                end

                WR_DATA: begin
                    // beat count, not wlast, decides where the burst ends
                    if (wvalid) begin
                        bresp_acc <= wr_resp_next;
                        if (is_last) begin
                            bvalid <= 1'b1;
                            bresp  <= wr_resp_next;
                            state  <= WR_RESP;
                        end else begin
                            cnt  <= cnt + 8'd1;
                            addr <= next_addr;
                        end
                    end
                end

                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        bresp  <= RESP_OKAY;
                        prio   <= ~prio;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a one-cycle-latency byte-writable SRAM model.
module tb_axi_sram_slave;
  localparam int RAM_AW = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:(1<<RAM_AW)-1];
  logic              pre_we = 1'b0;
  logic [RAM_AW-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // SRAM model: read data one cycle after a read enable, held otherwise
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no handshake, expected one within 20 cycles", tag);
  endtask

  task automatic preload(input logic [RAM_AW-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 1'b0;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = arready;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    if (!done) timeout("ar_handshake");
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 1'b0;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = awready;
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0;
    if (!done) timeout("aw_handshake");
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
    bit done;
    done = 1'b0;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = wready;
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    if (!done) timeout("w_handshake");
  endtask

  task automatic r_recv(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic [3:0] id);
    for (int n = 0; n < 20 && !rvalid; n++) tick();
    if (!rvalid) begin
      timeout({tag, "_rvalid"});
    end else begin
      chk({tag, "_rdata"}, rdata, d);
      chk({tag, "_rresp"}, 32'(rresp), 32'(resp));
      chk({tag, "_rlast"}, 32'(rlast), 32'(last));
      chk({tag, "_rid"}, 32'(rid), 32'(id));
      tick();
    end
  endtask

  task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    if (!bvalid) begin
      timeout({tag, "_bvalid"});
    end else begin
      chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
      chk({tag, "_bid"}, 32'(bid), 32'(id));
      tick();
    end
  endtask

  initial begin
    // reset behaviour, with valids asserted so gating of the readies is visible
    resetn = 1'b0;
    arvalid = 1'b1;
    wvalid = 1'b1;
    tick();
    tick();
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    arvalid = 1'b0;
    wvalid = 1'b0;
    resetn = 1'b1;
    tick();
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("idle_arready", 32'(arready), 1);

    preload(10'h010, 32'hDEADBEEF);
    preload(10'h080, 32'h11223344);

    // simultaneous AR+AW right after reset: read wins, then write wins over a fresh AR
    do_reset();
    arid = 4'd1; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h300; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    #1;
    chk("arb1_arready", 32'(arready), 1);
    chk("arb1_awready", 32'(awready), 0);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    r_recv("arb1_rd", 32'hDEADBEEF, 2'b00, 1'b1, 4'd1);
    arid = 4'd4; arvalid = 1'b1;
    #1;
    chk("arb2_arready", 32'(arready), 0);
    chk("arb2_awready", 32'(awready), 1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    w_send(32'h55, 4'hF, 1'b1);
    b_recv("arb2_b", 2'b00, 4'd2);
    #1;
    chk("arb3_arready", 32'(arready), 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    r_recv("arb3_rd", 32'hDEADBEEF, 2'b00, 1'b1, 4'd4);
    chk("arb_mem_c0", mem[10'h0C0], 32'h55);

    // single read latency: rvalid two cycles after the AR handshake
    ar_send(4'd3, 32'h40, 8'd0, 3'd2, 2'b01);
    chk("rd1_rvalid_t1", 32'(rvalid), 0);
    chk("rd1_ram_en", 32'(ram_en), 1);
    chk("rd1_ram_addr", 32'(ram_addr), 32'h10);
    tick();
    chk("rd1_rvalid_t2", 32'(rvalid), 1);
    r_recv("rd1", 32'hDEADBEEF, 2'b00, 1'b1, 4'd3);

    // INCR write burst of four beats, then read it back
    aw_send(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 1; i <= 4; i++) w_send(32'(i), 4'hF, i == 4);
    b_recv("incr_b", 2'b00, 4'd5);
    chk("incr_mem40", mem[10'h040], 32'd1);
    chk("incr_mem41", mem[10'h041], 32'd2);
    chk("incr_mem42", mem[10'h042], 32'd3);
    chk("incr_mem43", mem[10'h043], 32'd4);
    ar_send(4'd9, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 1; i <= 4; i++) r_recv("incr_rd", 32'(i), 2'b00, i == 4, 4'd9);

    // FIXED burst with byte strobes: only bytes 0 and 3 of word 0x80 change
    aw_send(4'd6, 32'h200, 8'd1, 3'd2, 2'b00);
    w_send(32'hAAAAAAAA, 4'h1, 1'b0);
    w_send(32'hBBBBBBBB, 4'h8, 1'b1);
    b_recv("fixed_b", 2'b00, 4'd6);
    chk("fixed_mem80", mem[10'h080], 32'hBB2233AA);

    // unsupported size on a read: SLVERR with zero data on both beats
    ar_send(4'd7, 32'h40, 8'd1, 3'd3, 2'b01);
    r_recv("rderr_b0", 32'd0, 2'b10, 1'b0, 4'd7);
    r_recv("rderr_b1", 32'd0, 2'b10, 1'b1, 4'd7);

    // early wlast: both beats still written, response SLVERR
    aw_send(4'd8, 32'h280, 8'd1, 3'd2, 2'b01);
    w_send(32'h77, 4'hF, 1'b1);
    w_send(32'h88, 4'hF, 1'b0);
    b_recv("wlast_b", 2'b10, 4'd8);
    chk("wlast_mem_a0", mem[10'h0A0], 32'h77);
    chk("wlast_mem_a1", mem[10'h0A1], 32'h88);

    // reserved burst type on a write: SLVERR and SRAM untouched
    aw_send(4'd7, 32'h300, 8'd0, 3'd2, 2'b11);
    w_send(32'h99, 4'hF, 1'b1);
    b_recv("wrerr_b", 2'b10, 4'd7);
    chk("wrerr_mem_c0", mem[10'h0C0], 32'h55);

    // rready held low: R payload must stay put
    rready = 1'b0;
    ar_send(4'd2, 32'h40, 8'd0, 3'd2, 2'b01);
    for (int n = 0; n < 5; n++) tick();
    for (int n = 0; n < 5; n++) begin
      chk("stall_rvalid", 32'(rvalid), 1);
      chk("stall_rdata", rdata, 32'hDEADBEEF);
      tick();
    end
    rready = 1'b1;
    r_recv("stall", 32'hDEADBEEF, 2'b00, 1'b1, 4'd2);

    // reset during beat 2 of a 4-beat write abandons the burst
    for (int i = 0; i < 4; i++) preload(10'(10'h0E0 + i), 32'hFFFFFFFF);
    aw_send(4'd1, 32'h380, 8'd3, 3'd2, 2'b01);
    w_send(32'h1, 4'hF, 1'b0);
    wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ram_en", 32'(ram_en), 0);
    chk("mid_rst_wready", 32'(wready), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(dbg_state), 0);
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    chk("mid_rst_bid", 32'(bid), 0);
    wvalid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk("mid_rst_mem_e0", mem[10'h0E0], 32'h1);
    chk("mid_rst_mem_e1", mem[10'h0E1], 32'hFFFFFFFF);
    chk("mid_rst_mem_e2", mem[10'h0E2], 32'hFFFFFFFF);
    chk("mid_rst_mem_e3", mem[10'h0E3], 32'hFFFFFFFF);
    chk("mid_rst_awready", 32'(awready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end
endmodule
